// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Desc     : UART receiver for 8-bit frames with optional even parity, one
//            stop bit and break handling. Each frame ends in a one-cycle valid
//            strobe that carries the error flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 8681,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_UART,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_ParityError,
    output logic       o_FrameError,
    output logic       o_Busy
);

    localparam logic [15:0] c_HALF = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] c_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic [15:0] r_count;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_par_err;
    logic        w_half_hit;
    logic        w_bit_hit;

    assign w_half_hit = (r_count == c_HALF);
    assign w_bit_hit  = (r_count == c_LAST);
    assign o_Busy     = (r_state != S_IDLE);

    // Line idles high, so the synchronizer resets to 1 to avoid a false start
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_UART;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_state_next = S_START;
            end
            S_START: begin
                if (w_half_hit) w_state_next = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_bit_hit && (r_bit_idx == 3'd7))
                    w_state_next = PARITY_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_bit_hit) w_state_next = S_STOP;
            end
            S_STOP: begin
                // Low stop bit means break; hold off until the line recovers
                if (w_bit_hit) w_state_next = r_rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (r_rx_s) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_count   <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_par_err <= 1'b0;
        end else begin
            case (r_state)
                S_START: begin
                    if (w_half_hit) begin
                        r_count   <= 16'd0;
                        r_bit_idx <= 3'd0;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_hit) begin
                        r_count   <= 16'd0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_hit) begin
                        r_count   <= 16'd0;
                        r_par_err <= (^r_shift) ^ r_rx_s;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_hit) r_count <= 16'd0;
                    else           r_count <= r_count + 16'd1;
                end
                default: r_count <= 16'd0;
            endcase
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Data        <= 8'd0;
            o_Valid       <= 1'b0;
            o_ParityError <= 1'b0;
            o_FrameError  <= 1'b0;
        end else begin
            o_Valid <= 1'b0;
            if ((r_state == S_STOP) && w_bit_hit) begin
                o_Valid       <= 1'b1;
                o_Data        <= r_shift;
                o_ParityError <= PARITY_EN & r_par_err;
                o_FrameError  <= ~r_rx_s;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the board's UART link: the counterpart to the existing transmitter. It recovers 8-bit even-parity frames from the `i_UART` line at 100 MHz / 8681 clocks per bit (about 11520 baud). Each decoded byte is presented on `o_Data` with a single-cycle `o_Valid` strobe and error flags. It sits between the external RX pin and the LED/command logic that consumes received bytes.

## Interface
- `CLKS_PER_BIT`, default 8681: clock cycles per bit. Legal range 4..65535.
- `PARITY_EN`, default 1:
  - 1: the frame carries an even-parity bit after the data.
  - 0: no parity bit; `o_ParityError` is held 0.

Ports:
- `i_Clock`  input  1  system clock, 100 MHz.
- `i_Reset`  input  1  asynchronous, active-high reset.
- `i_UART`  input  1  serial line; idles high; asynchronous to `i_Clock`.
- `o_Data`  output  8  last received byte; held until the next frame completes.
- `o_Valid`  output  1  one-cycle pulse when a frame completes.
- `o_ParityError`  output  1  parity mismatch on the last frame; valid with `o_Valid`, held until the next frame.
- `o_FrameError`  output  1  stop bit sampled low on the last frame; valid with `o_Valid`, held until the next frame.
- `o_Busy`  output  1  high whenever the state is not IDLE.

## Operation
- **Frame format:**
  - Start bit (0).
  - 8 data bits, LSB first.
  - Parity bit, only when `PARITY_EN`=1. Even parity: the XOR of the 8 data bits.
  - Stop bit (1).
- **Synchronizer:** `i_UART` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1. Only `rx_s` is used downstream.
- **Counters:**
  - Bit-timing counter: 16 bits. `HALF` = `CLKS_PER_BIT`/2 (integer division).
  - Bit index: 3 bits.
  - Shift register: 8 bits. Each sampled data bit shifts in at the MSB end, so the LSB ends up at bit 0.
- **States:**
  - IDLE:
    - Counter is cleared.
    - `rx_s`=0 → START.
  - START:
    - At counter=`HALF`, sample `rx_s`.
    - Sample 0 → DATA, counter cleared, bit index cleared.
    - Sample 1 (glitch) → IDLE. No output change.
  - DATA:
    - At counter=`CLKS_PER_BIT`-1, sample `rx_s` into the shift register, clear the counter, and increment the bit index.
    - After bit index 7: → PARITY if `PARITY_EN`, else → STOP.
  - PARITY:
    - At counter=`CLKS_PER_BIT`-1, sample the parity bit.
    - Store the mismatch result (XOR of the 8 data bits ^ sampled bit).
    - → STOP.
  - STOP:
    - At counter=`CLKS_PER_BIT`-1, sample the stop bit.
    - Next clock: load `o_Data` from the shift register, pulse `o_Valid`, update both error flags.
    - Stop bit 1 → IDLE.
    - Stop bit 0 → BREAK.
  - BREAK:
    - Wait for `rx_s`=1, then → IDLE.
    - Prevents a held-low line (break) from being decoded as repeated 0x00 frames.
- **Error frames:** `o_Valid` pulses for every completed frame, including errored ones. The consumer qualifies each byte with the error flags.
- **Reset (any time, including mid-frame):**
  - State → IDLE; counter, bit index and shift register cleared.
  - `o_Data`=0x00, `o_Valid`=0, `o_ParityError`=0, `o_FrameError`=0, `o_Busy`=0.
  - The partial frame is discarded.

## Timing
- **Synchronizer latency:** `rx_s` follows `i_UART` 2 clocks later.
- **Sample points:**
  - Start bit: `HALF` clocks after IDLE→START, i.e. mid-bit.
  - Each later bit: exactly `CLKS_PER_BIT` clocks after the previous sample.
  - The stop sample falls `HALF` + (9 + `PARITY_EN`)·`CLKS_PER_BIT` clocks after IDLE→START.
- **`o_Valid` timing:** registered; high for exactly one clock, on the clock after the stop sample. `o_Data` and both flags update on that same edge.
- **Back-to-back frames:** a new start edge arriving immediately after the nominal stop bit end is accepted.
  - After a good stop, IDLE is re-entered about half a bit before the stop bit ends.
  - No minimum idle gap is required.
- **Baud tolerance:** sampling stays within the bit for transmitter baud error of ±4%.
- **Glitch rejection:** a low pulse shorter than `HALF` clocks never leaves START, and `o_Valid` stays 0.

## Test plan
Bench uses `CLKS_PER_BIT`=16 (`HALF`=8), `PARITY_EN`=1 unless noted.
1. Send 0xA5 with parity 0, stop 1 → one `o_Valid` pulse; `o_Data`=0xA5; `o_ParityError`=0; `o_FrameError`=0; `o_Busy` low after the pulse.
2. Send 0x01 with parity 0 (correct parity is 1) → `o_Data`=0x01, `o_ParityError`=1. Then send 0x03 with parity 0 → `o_ParityError` returns to 0.
3. Send 0x3C with stop=0, hold the line low for 3 bit times, then idle high, then send 0x55 →
   - First `o_Valid`: `o_Data`=0x3C, `o_FrameError`=1.
   - No further pulse while the line is low.
   - Next pulse: `o_Data`=0x55, `o_FrameError`=0.
4. Drive a 4-clock low glitch on the idle line → no `o_Valid`; `o_Busy` returns to 0 within `HALF`+3 clocks.
5. Send 0x00 then 0xFF with zero idle gap, then repeat with `PARITY_EN`=0 → two pulses each time; `o_Data`=0x00 then 0xFF; no errors.
6. Assert `i_Reset` for 1 clock during data bit 3 of 0x12, then send 0x7E →
   - All outputs read 0 immediately.
   - No pulse for 0x12.
   - Next pulse: `o_Data`=0x7E, no errors.
